// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file with pending scoreboard.
package regfile_pkg;

  localparam int unsigned MAX_READ = 4;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // An address is usable when it is inside the array and is not the hardwired zero register.
  function automatic logic addr_valid(input logic [31:0] addr,
                                      input int unsigned num_regs,
                                      input logic        zero_reg);
    return (addr < num_regs) && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of the register file: read ports, write, reserve, clear and init status.
interface regfile_scoreboard_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned AW       = $clog2(NUM_REGS)
);

  logic [NUM_READ*AW-1:0]   read_address;
  logic [NUM_READ*XLEN-1:0] read_data;
  logic [NUM_READ-1:0]      read_pending;
  logic [AW-1:0]            write_address;
  logic [XLEN-1:0]          write_value;
  logic                     write_enable;
  logic [AW-1:0]            reserve_address;
  logic                     reserve_enable;
  logic                     clear_req;
  logic                     init_done;

  modport master (
    output read_address, write_address, write_value, write_enable,
           reserve_address, reserve_enable, clear_req,
    input  read_data, read_pending, init_done
  );

  modport slave (
    input  read_address, write_address, write_value, write_enable,
           reserve_address, reserve_enable, clear_req,
    output read_data, read_pending, init_done
  );

endinterface

// File: rtl/regfile_init_ctrl.sv
// Clear-sweep controller: walks every entry once after reset or a clear request, then enables the file.
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          init_done,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr
);

  localparam logic [0:0]    ST_INIT = INIT;
  localparam logic [0:0]    ST_RUN  = RUN;
  localparam logic [AW-1:0] LAST    = AW'(NUM_REGS - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A clear request during the sweep is ignored; the running sweep is not restarted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign init_done  = (state_q == ST_RUN);
  assign sweep_we   = (state_q == ST_INIT);
  assign sweep_addr = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, optional write bypass and per-register pending bits.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input logic               clk,
  input logic               rst_n,
  regfile_scoreboard_if.slave bus
);

  logic [XLEN-1:0]     mem [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                run;
  logic                sweep_we;
  logic [AW-1:0]       sweep_addr;
  logic                wr_ok, rs_ok;
  logic [AW-1:0]       rd_addr;

  regfile_init_ctrl #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_init_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (bus.clear_req),
    .init_done  (bus.init_done),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  assign run   = bus.init_done;
  assign wr_ok = run && bus.write_enable &&
                 addr_valid(32'(bus.write_address), NUM_REGS, ZERO_REG != 0);
  assign rs_ok = run && bus.reserve_enable &&
                 addr_valid(32'(bus.reserve_address), NUM_REGS, ZERO_REG != 0);

  // Sweep and pipeline writes never overlap: pipeline writes only count once running.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (wr_ok) begin
      mem[bus.write_address] <= bus.write_value;
    end
  end

  // Reserve is applied after the write so a same-cycle producer leaves the register pending.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (sweep_we && (sweep_addr == AW'(r))) pend_d[r] = 1'b0;
      if (wr_ok && (bus.write_address == AW'(r))) pend_d[r] = 1'b0;
      if (rs_ok && (bus.reserve_address == AW'(r))) pend_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Read ports: zero while sweeping or for invalid addresses, forwarded write data when enabled.
  always_comb begin
    bus.read_data    = '0;
    bus.read_pending = '0;
    rd_addr          = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      rd_addr = bus.read_address[i*AW +: AW];
      if (run && addr_valid(32'(rd_addr), NUM_REGS, ZERO_REG != 0)) begin
        bus.read_data[i*XLEN +: XLEN] = mem[rd_addr];
        bus.read_pending[i]           = pend_q[rd_addr];
        if ((BYPASS != 0) && wr_ok && (bus.write_address == rd_addr)) begin
          bus.read_data[i*XLEN +: XLEN] = bus.write_value;
          bus.read_pending[i]           = 1'b0;
        end
      end
    end
  end

endmodule
